// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART frame definitions (RX and TX sides): data width,
//            receiver state encoding and the even-parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame: start, UART_DBITS data bits MSB first, even parity, stop
    localparam int UART_DBITS      = 8;
    localparam int UART_FRAME_BITS = UART_DBITS + 3;

    typedef enum logic [2:0] {
        URX_IDLE      = 3'd0,
        URX_START     = 3'd1,
        URX_DATA      = 3'd2,
        URX_PAR       = 3'd3,
        URX_STOP      = 3'd4,
        URX_WAIT_IDLE = 3'd5
    } urx_state_t;

    // Even parity: the parity bit equals the XOR of the data bits
    function automatic logic even_parity(input logic [UART_DBITS-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_if
// Purpose  : Serial line input and received-byte outputs of the UART frame
//            receiver. master = receiver, slave = line driver / consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic                  uart_rx;
    logic [UART_DBITS-1:0] rx_data;
    logic                  rx_vld;
    logic                  rx_perr;
    logic                  rx_ferr;
    logic                  rx_busy;

    modport master (
        input  uart_rx,
        output rx_data,
        output rx_vld,
        output rx_perr,
        output rx_ferr,
        output rx_busy
    );

    modport slave (
        output uart_rx,
        input  rx_data,
        input  rx_vld,
        input  rx_perr,
        input  rx_ferr,
        input  rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Purpose  : Generic two-flop synchronizer for a single asynchronous bit,
//            with a configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : UART frame receiver: start, 8 data bits MSB first, even parity,
//            stop. Strobes each byte with parity/framing flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_frame_if.master bus
);
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    // Start bit is checked mid-bit; every later sample is one bit period on
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_m1  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic                  w_rxs;
    urx_state_t            r_state, w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic [2:0]            r_idx, w_idx_nxt;
    logic [UART_DBITS-1:0] r_shift, w_shift_nxt;
    logic                  r_perr_pend, w_perr_pend_nxt;
    logic                  w_strobe;
    logic                  w_ferr;
    logic [UART_DBITS-1:0] r_data;
    logic                  r_vld;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_busy;

    bit_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.uart_rx),
        .o_q (w_rxs)
    );

    // Next-state, sample-point and strobe decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_perr_pend_nxt = r_perr_pend;
        w_strobe        = 1'b0;
        w_ferr          = 1'b0;
        case (r_state)
            URX_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = URX_START;
                end
            end
            URX_START: begin
                if (r_cnt == c_half_m1) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        // Line back high at mid start bit: a glitch
                        w_state_nxt = URX_IDLE;
                    end else begin
                        w_state_nxt = URX_DATA;
                        w_idx_nxt   = 3'd7;
                    end
                end
            end
            URX_DATA: begin
                if (r_cnt == c_bit_m1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_shift[UART_DBITS-2:0], w_rxs};
                    if (r_idx == 3'd0) begin
                        w_state_nxt = URX_PAR;
                    end else begin
                        w_idx_nxt = r_idx - 1'b1;
                    end
                end
            end
            URX_PAR: begin
                if (r_cnt == c_bit_m1) begin
                    w_cnt_nxt       = '0;
                    w_perr_pend_nxt = (even_parity(r_shift) != w_rxs);
                    w_state_nxt     = URX_STOP;
                end
            end
            URX_STOP: begin
                if (r_cnt == c_bit_m1) begin
                    w_cnt_nxt = '0;
                    w_strobe  = 1'b1;
                    if (w_rxs) begin
                        // Back to IDLE mid stop bit so a following start edge is seen
                        w_state_nxt = URX_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = URX_WAIT_IDLE;
                    end
                end
            end
            URX_WAIT_IDLE: begin
                // A break or stuck-low line must not look like a new start bit
                w_cnt_nxt = '0;
                if (w_rxs) begin
                    w_state_nxt = URX_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = URX_IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= URX_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_perr_pend <= 1'b0;
            r_data      <= '0;
            r_vld       <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_perr_pend <= w_perr_pend_nxt;
            r_vld       <= w_strobe;
            r_busy      <= (w_state_nxt != URX_IDLE);
            if (w_strobe) begin
                r_data <= r_shift;
                r_perr <= r_perr_pend;
                r_ferr <= w_ferr;
            end
        end
    end

    assign bus.rx_data = r_data;
    assign bus.rx_vld  = r_vld;
    assign bus.rx_perr = r_perr;
    assign bus.rx_ferr = r_ferr;
    assign bus.rx_busy = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame: table of clean/parity
//            frames plus framing error, glitch and reset-mid-frame sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;
    localparam int N       = 10;
    localparam int HALF    = N / 2;
    localparam int PERIOD  = 10;
    localparam int EXP_LAT = 3 + HALF + 10 * N;   // 108 cycles

    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_rx_frame_if bus ();

    uart_rx_frame #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        time        t;
    } strobe_t;

    strobe_t sq[$];

    // Record every strobe seen on the falling edge
    always @(negedge clk) begin
        if (bus.rx_vld === 1'b1) begin
            sq.push_back('{bus.rx_data, bus.rx_perr, bus.rx_ferr, $time});
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       flip;
        int         gap;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        bus.uart_rx = v;
        repeat (N) @(negedge clk);
    endtask

    // Drives one frame from a falling edge; leaves the stop level on the line
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_v, output time t0);
        t0 = $time;
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit((^d) ^ par_flip);
        send_bit(stop_v);
    endtask

    task automatic recv_check(input string name, input logic [7:0] exp_d,
                              input logic exp_pe, input logic exp_fe, input time t0);
        strobe_t s;
        int      w;
        w = 0;
        while (sq.size() == 0 && w < 3 * N) begin
            @(negedge clk);
            w++;
        end
        if (sq.size() == 0) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            s = sq.pop_front();
            check({name, "_data"}, {24'd0, s.d}, {24'd0, exp_d});
            check({name, "_perr"}, {31'd0, s.pe}, {31'd0, exp_pe});
            check({name, "_ferr"}, {31'd0, s.fe}, {31'd0, exp_fe});
            check({name, "_lat"}, 32'((s.t - t0) / PERIOD), 32'(EXP_LAT));
            check({name, "_extra"}, 32'(sq.size()), 32'd0);
        end
    endtask

    initial begin
        #(PERIOD * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        time t0;
        total = 0;
        bad   = 0;

        vecs[0] = '{8'h55, 1'b0, 100, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hAA, 1'b0,  50, 8'hAA, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b0,   0, 8'h55, 1'b0, 1'b0};
        vecs[3] = '{8'hAA, 1'b0,   0, 8'hAA, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b0,  10, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0,  10, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hA5, 1'b1,  20, 8'hA5, 1'b1, 1'b0};

        rst         = 1'b1;
        bus.uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", {24'd0, bus.rx_data}, 32'd0);
        check("reset_vld",  {31'd0, bus.rx_vld},  32'd0);
        check("reset_perr", {31'd0, bus.rx_perr}, 32'd0);
        check("reset_ferr", {31'd0, bus.rx_ferr}, 32'd0);
        check("reset_busy", {31'd0, bus.rx_busy}, 32'd0);

        // Table of clean and parity-error frames, including zero-gap pairs
        for (int v = 0; v < 7; v++) begin
            repeat (vecs[v].gap) @(negedge clk);
            send_frame(vecs[v].d, vecs[v].flip, 1'b1, t0);
            recv_check($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_pe,
                       vecs[v].exp_fe, t0);
        end

        // Flags and data hold after the parity-error strobe
        repeat (30) @(negedge clk);
        check("perr_hold", {31'd0, bus.rx_perr}, 32'd1);
        check("data_hold", {24'd0, bus.rx_data}, 32'h0000_00A5);

        // Framing error: stop low, line held low three more bit times
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        repeat (3 * N) @(negedge clk);
        recv_check("ferr", 8'h3C, 1'b0, 1'b1, t0);
        check("ferr_busy_low_line", {31'd0, bus.rx_busy}, 32'd1);
        bus.uart_rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("ferr_busy_after", {31'd0, bus.rx_busy}, 32'd0);
        check("ferr_no_2nd", 32'(sq.size()), 32'd0);
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b1, t0);
        recv_check("after_ferr", 8'h81, 1'b0, 1'b0, t0);

        // Glitch: three-cycle low pulse on an idle line
        repeat (30) @(negedge clk);
        bus.uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.uart_rx = 1'b1;
        check("glitch_busy_start", {31'd0, bus.rx_busy}, 32'd1);
        repeat (HALF) @(negedge clk);
        check("glitch_busy_end", {31'd0, bus.rx_busy}, 32'd0);
        repeat (12 * N) @(negedge clk);
        check("glitch_no_vld", 32'(sq.size()), 32'd0);

        // Reset during data bit 4 of 0xF0; the host abandons the frame
        bus.uart_rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 7; i >= 5; i--) send_bit(1'b1);
        bus.uart_rx = 1'b1;
        repeat (HALF) @(negedge clk);
        check("midrst_busy_before", {31'd0, bus.rx_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", {24'd0, bus.rx_data}, 32'd0);
        check("midrst_vld",  {31'd0, bus.rx_vld},  32'd0);
        check("midrst_perr", {31'd0, bus.rx_perr}, 32'd0);
        check("midrst_ferr", {31'd0, bus.rx_ferr}, 32'd0);
        check("midrst_busy", {31'd0, bus.rx_busy}, 32'd0);
        repeat (12 * N) @(negedge clk);
        check("midrst_no_vld", 32'(sq.size()), 32'd0);
        send_frame(8'h0F, 1'b0, 1'b1, t0);
        recv_check("after_rst", 8'h0F, 1'b0, 1'b0, t0);

        repeat (2 * N) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
